// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
// Emits every fully interior window one cycle after its bottom-right pixel is accepted.
module window_3x3_gen #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [DATA_W-1:0]          x_0,
  output logic [DATA_W-1:0]          x_1,
  output logic [DATA_W-1:0]          x_2,
  output logic [DATA_W-1:0]          x_3,
  output logic [DATA_W-1:0]          x_4,
  output logic [DATA_W-1:0]          x_5,
  output logic [DATA_W-1:0]          x_6,
  output logic [DATA_W-1:0]          x_7,
  output logic [DATA_W-1:0]          x_8,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic [DATA_W-1:0] lb_a_q [IMG_W];
  logic [DATA_W-1:0] lb_b_q [IMG_W];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];
  logic [DATA_W-1:0] out_q [9];
  logic [DATA_W-1:0] out_d [9];
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [RW-1:0]     win_row_q, win_row_d;
  logic [CW-1:0]     win_col_q, win_col_d;

  // Position of the pixel on the bus; sof forces it to (0,0)
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    rd_a    = lb_a_q[cur_col];
    rd_b    = lb_b_q[cur_col];
  end

  // Next-state for counters, window taps and registered outputs
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    out_d        = out_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (pix_valid) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      for (int k = 0; k < 3; k++) begin
        win_d[3*k]   = win_q[3*k+1];
        win_d[3*k+1] = win_q[3*k+2];
      end
      win_d[2] = rd_b;
      win_d[5] = rd_a;
      win_d[8] = pix_in;
      // Gating on c>=2 also hides columns left over from the previous line
      if (cur_row >= RW'(2) && cur_col >= CW'(2)) begin
        win_valid_d  = 1'b1;
        out_d        = win_d;
        win_row_d    = cur_row - RW'(1);
        win_col_d    = cur_col - CW'(1);
        frame_done_d = (cur_row == RowLast) && (cur_col == ColLast);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      win_q        <= win_d;
      out_q        <= out_d;
    end
  end

  // Line buffers: read-before-write, lb_a ages into lb_b; contents need no reset
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_b_q[cur_col] <= rd_a;
      lb_a_q[cur_col] <= pix_in;
    end
  end

  assign x_0        = out_q[0];
  assign x_1        = out_q[1];
  assign x_2        = out_q[2];
  assign x_3        = out_q[3];
  assign x_4        = out_q[4];
  assign x_5        = out_q[5];
  assign x_6        = out_q[6];
  assign x_7        = out_q[7];
  assign x_8        = out_q[8];
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a 4x4 instance for directed scenarios and a 37x23 instance
// with random pixels. An image-level model predicts each window from the pixels sent.
module tb_window_3x3_gen;

  localparam int W0 = 4;
  localparam int H0 = 4;
  localparam int W1 = 37;
  localparam int H1 = 23;

  localparam logic [8:0][8:0] First0 =
    {9'd34, 9'd33, 9'd32, 9'd18, 9'd17, 9'd16, 9'd2, 9'd1, 9'd0};
  localparam logic [8:0][8:0] First100 =
    {9'd134, 9'd133, 9'd132, 9'd118, 9'd117, 9'd116, 9'd102, 9'd101, 9'd100};

  typedef struct {
    logic [8:0][8:0] x;
    int              row;
    int              col;
    bit              fd;
    int              due;
  } exp_t;

  typedef struct {
    logic [8:0][8:0] x;
    int              row;
    int              col;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_v, pv_v, sof_v;
  logic [1:0][8:0] pin;
  logic [1:0]      wv, fd;
  logic [1:0]      wr0, wc0;
  logic [4:0]      wr1;
  logic [5:0]      wc1;
  logic [8:0][8:0] xa, xb;

  int   pcyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_on = 0;
  int   nwin [2];
  int   nfd [2];
  int   br [2];
  int   bc [2];
  logic [8:0] img [2][H1][W1];
  exp_t q0[$];
  exp_t q1[$];
  win_t log0[$];

  always @(posedge clk) pcyc <= pcyc + 1;

  window_3x3_gen #(.DATA_W(9), .IMG_W(W0), .IMG_H(H0)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .pix_in(pin[0]), .pix_valid(pv_v[0]), .sof(sof_v[0]),
    .x_0(xa[0]), .x_1(xa[1]), .x_2(xa[2]), .x_3(xa[3]), .x_4(xa[4]),
    .x_5(xa[5]), .x_6(xa[6]), .x_7(xa[7]), .x_8(xa[8]),
    .win_valid(wv[0]), .win_row(wr0), .win_col(wc0), .frame_done(fd[0])
  );

  window_3x3_gen #(.DATA_W(9), .IMG_W(W1), .IMG_H(H1)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .pix_in(pin[1]), .pix_valid(pv_v[1]), .sof(sof_v[1]),
    .x_0(xb[0]), .x_1(xb[1]), .x_2(xb[2]), .x_3(xb[3]), .x_4(xb[4]),
    .x_5(xb[5]), .x_6(xb[6]), .x_7(xb[7]), .x_8(xb[8]),
    .win_valid(wv[1]), .win_row(wr1), .win_col(wc1), .frame_done(fd[1])
  );

  function automatic int wof(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int hof(int i);
    return (i == 0) ? H0 : H1;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, pcyc, act, want);
    end
  endtask

  // Drive one accepted pixel and predict the window it completes, if any
  task automatic send(int i, logic [8:0] p, bit s);
    int   r, c;
    exp_t e;
    @(negedge clk);
    pv_v[i]  = 1'b1;
    sof_v[i] = s;
    pin[i]   = p;
    if (s) begin
      br[i] = 0;
      bc[i] = 0;
    end
    r = br[i];
    c = bc[i];
    img[i][r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++) e.x[3*a+b] = img[i][r-2+a][c-2+b];
      e.row = r - 1;
      e.col = c - 1;
      e.fd  = (r == hof(i) - 1) && (c == wof(i) - 1);
      e.due = pcyc + 1;
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    bc[i] = c + 1;
    if (bc[i] == wof(i)) begin
      bc[i] = 0;
      br[i] = (r + 1 == hof(i)) ? 0 : r + 1;
    end
  endtask

  task automatic idle(int i, int n);
    repeat (n) begin
      @(negedge clk);
      pv_v[i]  = 1'b0;
      sof_v[i] = 1'b0;
    end
  endtask

  task automatic send_frame(int i, int base, bit first_sof, bit gaps);
    for (int r = 0; r < hof(i); r++)
      for (int c = 0; c < wof(i); c++) begin
        send(i, 9'(base + 16 * r + c), first_sof && r == 0 && c == 0);
        if (gaps) idle(i, $urandom_range(0, 5));
      end
  endtask

  // Per-cycle comparison of both instances against the predicted window queues
  initial begin
    exp_t            e;
    bit              ev;
    logic            a_wv, a_fd;
    logic [8:0][8:0] a_x;
    int              a_r, a_c;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int i = 0; i < 2; i++) begin
          if (i == 0) begin
            ev = (q0.size() > 0) && (q0[0].due == pcyc);
            if (ev) e = q0.pop_front();
            a_wv = wv[0]; a_fd = fd[0]; a_x = xa; a_r = int'(wr0); a_c = int'(wc0);
          end else begin
            ev = (q1.size() > 0) && (q1[0].due == pcyc);
            if (ev) e = q1.pop_front();
            a_wv = wv[1]; a_fd = fd[1]; a_x = xb; a_r = int'(wr1); a_c = int'(wc1);
          end
          chk($sformatf("win_valid[%0d]", i), a_wv, ev);
          chk($sformatf("frame_done[%0d]", i), a_fd, ev && e.fd);
          if (ev) begin
            chk($sformatf("x[%0d]", i), a_x, e.x);
            chk($sformatf("win_row[%0d]", i), a_r, e.row);
            chk($sformatf("win_col[%0d]", i), a_c, e.col);
          end
          if (a_wv === 1'b1) begin
            nwin[i]++;
            if (i == 0) log0.push_back('{x: a_x, row: a_r, col: a_c});
          end
          if (a_fd === 1'b1) nfd[i]++;
        end
      end
    end
  end

  initial begin
    int f0;
    for (int i = 0; i < 2; i++) begin
      nwin[i] = 0; nfd[i] = 0; br[i] = 0; bc[i] = 0;
    end
    rst_v = 2'b11; pv_v = '0; sof_v = '0; pin = '0;
    repeat (3) @(negedge clk);
    rst_v  = 2'b00;
    chk_on = 1'b1;

    // Basic frame
    log0.delete(); f0 = nfd[0];
    send_frame(0, 0, 1'b1, 1'b0);
    idle(0, 3);
    chk("basic_count", log0.size(), 4);
    chk("basic_fd_count", nfd[0] - f0, 1);
    if (log0.size() == 4) begin
      chk("basic_first_x", log0[0].x, First0);
      chk("basic_first_rc", {log0[0].row, log0[0].col}, {32'd1, 32'd1});
      chk("basic_last_x8", log0[3].x[8], 51);
      chk("basic_last_rc", {log0[3].row, log0[3].col}, {32'd2, 32'd2});
    end

    // Gapped input
    log0.delete();
    send_frame(0, 0, 1'b1, 1'b1);
    idle(0, 3);
    chk("gap_count", log0.size(), 4);
    if (log0.size() > 0) chk("gap_first_x", log0[0].x, First0);

    // Back-to-back frames, second one relies on the counter wrap
    log0.delete(); f0 = nfd[0];
    send_frame(0, 0, 1'b1, 1'b0);
    send_frame(0, 100, 1'b0, 1'b0);
    idle(0, 3);
    chk("b2b_count", log0.size(), 8);
    chk("b2b_fd_count", nfd[0] - f0, 2);
    if (log0.size() == 8) chk("b2b_second_first_x", log0[4].x, First100);

    // sof resync at (1,2): truncated frame, then a full frame
    log0.delete(); f0 = nfd[0];
    for (int k = 0; k < 6; k++) send(0, 9'(16 * (k / 4) + k % 4), k == 0);
    send_frame(0, 0, 1'b1, 1'b0);
    idle(0, 3);
    chk("resync_count", log0.size(), 4);
    chk("resync_fd_count", nfd[0] - f0, 1);
    if (log0.size() > 0) chk("resync_first_x", log0[0].x, First0);

    // Reset mid-frame while pixel (2,1) is on the bus
    log0.delete(); f0 = nfd[0];
    for (int k = 0; k < 9; k++) send(0, 9'(16 * (k / 4) + k % 4), k == 0);
    @(negedge clk);
    rst_v[0] = 1'b1; pv_v[0] = 1'b1; sof_v[0] = 1'b0; pin[0] = 9'd33;
    @(negedge clk);
    rst_v[0] = 1'b0; pv_v[0] = 1'b0;
    br[0] = 0; bc[0] = 0;
    chk("rst_x", xa, '0);
    chk("rst_ctl", {wv[0], fd[0], wr0, wc0}, '0);
    send_frame(0, 0, 1'b0, 1'b0);
    idle(0, 3);
    chk("rstmid_count", log0.size(), 4);
    chk("rstmid_fd_count", nfd[0] - f0, 1);
    if (log0.size() > 0) chk("rstmid_first_x", log0[0].x, First0);

    // Larger non-power-of-two frame with random pixels
    f0 = nwin[1];
    for (int r = 0; r < H1; r++)
      for (int c = 0; c < W1; c++) send(1, 9'($urandom_range(0, 511)), r == 0 && c == 0);
    idle(1, 4);
    chk("size_count", nwin[1] - f0, (W1 - 2) * (H1 - 2));
    chk("size_fd_count", nfd[1], 1);

    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
